// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined restoring square root (one root bit per stage) with AXI4-Stream handshake.
// Define SQRT_REM_EN to register the final remainder onto m_axis_dout_trem; otherwise trem reads zero.
module sqrt_pipe #(
   parameter  int DIN_W  = 16,
   parameter  int USER_W = 8,
   localparam int DOUT_W = DIN_W / 2
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [DIN_W-1:0]              s_axis_cartesian_tdata,
   input  logic [USER_W-1:0]             s_axis_cartesian_tuser,
   input  logic                          s_axis_cartesian_tlast,
   input  logic                          s_axis_cartesian_tvalid,
   output logic                          s_axis_cartesian_tready,
   output logic [DOUT_W-1:0]             m_axis_dout_tdata,
   output logic [DOUT_W:0]               m_axis_dout_trem,
   output logic [USER_W-1:0]             m_axis_dout_tuser,
   output logic                          m_axis_dout_tlast,
   output logic                          m_axis_dout_tvalid,
   input  logic                          m_axis_dout_tready,
   output logic [$clog2(DOUT_W+2)-1:0]   inflight
);

   localparam int RW = DOUT_W + 1;
   localparam int NM = (DOUT_W > 1) ? DOUT_W - 1 : 1;
   localparam int CW = $clog2(DOUT_W + 2);

   logic ce;

   // Per-stage valid bits; index DOUT_W-1 is the output register's valid.
   logic vld_q [DOUT_W];

   // Intermediate stage registers (stages 0..DOUT_W-2); not valid-qualified, so no reset.
   logic [DOUT_W-1:0] root_q [NM];
   logic [RW-1:0]     rem_q  [NM];
   logic [DIN_W-1:0]  rad_q  [NM];
   logic [USER_W-1:0] user_q [NM];
   logic              last_q [NM];

   logic              vld_in  [DOUT_W];
   logic [DOUT_W-1:0] root_in [DOUT_W];
   logic [RW-1:0]     rem_in  [DOUT_W];
   logic [DIN_W-1:0]  rad_in  [DOUT_W];
   logic [USER_W-1:0] user_in [DOUT_W];
   logic              last_in [DOUT_W];

   logic [DOUT_W-1:0] root_d [DOUT_W];
   logic [RW-1:0]     rem_d  [DOUT_W];
   logic [DIN_W-1:0]  rad_d  [DOUT_W];
   logic [RW+1:0]     remx   [DOUT_W];
   logic [RW+1:0]     diff   [DOUT_W];
   logic [DOUT_W-1:0] unused_hi;
   logic              unused_tail;

   logic [DOUT_W-1:0] out_root_q;
   logic [USER_W-1:0] out_user_q;
   logic              out_last_q;
`ifdef SQRT_REM_EN
   logic [RW-1:0]     out_rem_q;
`endif

   logic [CW-1:0] inflight_q, inflight_d;
   logic          in_hs, out_hs;

   assign ce = !vld_q[DOUT_W-1] || m_axis_dout_tready;

   always_comb begin
      vld_in[0]  = s_axis_cartesian_tvalid;
      root_in[0] = '0;
      rem_in[0]  = '0;
      rad_in[0]  = s_axis_cartesian_tdata;
      user_in[0] = s_axis_cartesian_tuser;
      last_in[0] = s_axis_cartesian_tlast;
      for (int unsigned k = 1; k < DOUT_W; k++) begin
         vld_in[k]  = vld_q[k-1];
         root_in[k] = root_q[k-1];
         rem_in[k]  = rem_q[k-1];
         rad_in[k]  = rad_q[k-1];
         user_in[k] = user_q[k-1];
         last_in[k] = last_q[k-1];
      end
   end

   // Trial subtraction is done two bits wider than the partial remainder; the top bit is the borrow.
   always_comb begin
      for (int unsigned k = 0; k < DOUT_W; k++) begin
         remx[k] = {rem_in[k], rad_in[k][DIN_W-1 -: 2]};
         diff[k] = remx[k] - {1'b0, root_in[k], 2'b01};
         if (diff[k][RW+1]) begin
            rem_d[k]  = remx[k][RW-1:0];
            root_d[k] = root_in[k] << 1;
         end else begin
            rem_d[k]  = diff[k][RW-1:0];
            root_d[k] = (root_in[k] << 1) | DOUT_W'(1);
         end
         rad_d[k]     = rad_in[k] << 2;
         unused_hi[k] = ^{remx[k][RW+1:RW], diff[k][RW]};
      end
   end

`ifdef SQRT_REM_EN
   assign unused_tail = ^rad_d[DOUT_W-1];
`else
   assign unused_tail = ^{rad_d[DOUT_W-1], rem_d[DOUT_W-1]};
`endif

   always_ff @(posedge aclk) begin
      if (ce) begin
         for (int unsigned k = 0; k + 1 < DOUT_W; k++) begin
            root_q[k] <= root_d[k];
            rem_q[k]  <= rem_d[k];
            rad_q[k]  <= rad_d[k];
            user_q[k] <= user_in[k];
            last_q[k] <= last_in[k];
         end
      end
   end

   assign in_hs  = s_axis_cartesian_tvalid && ce;
   assign out_hs = vld_q[DOUT_W-1] && m_axis_dout_tready;

   always_comb begin
      inflight_d = inflight_q;
      if (in_hs && !out_hs) begin
         inflight_d = inflight_q + CW'(1);
      end else if (!in_hs && out_hs) begin
         inflight_d = inflight_q - CW'(1);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int unsigned k = 0; k < DOUT_W; k++) begin
            vld_q[k] <= 1'b0;
         end
         out_root_q <= '0;
         out_user_q <= '0;
         out_last_q <= 1'b0;
`ifdef SQRT_REM_EN
         out_rem_q  <= '0;
`endif
         inflight_q <= '0;
      end else begin
         if (ce) begin
            for (int unsigned k = 0; k < DOUT_W; k++) begin
               vld_q[k] <= vld_in[k];
            end
            out_root_q <= root_d[DOUT_W-1];
            out_user_q <= user_in[DOUT_W-1];
            out_last_q <= last_in[DOUT_W-1];
`ifdef SQRT_REM_EN
            out_rem_q  <= rem_d[DOUT_W-1];
`endif
         end
         inflight_q <= inflight_d;
      end
   end

   assign s_axis_cartesian_tready = ce;
   assign m_axis_dout_tvalid      = vld_q[DOUT_W-1];
   assign m_axis_dout_tdata       = out_root_q;
   assign m_axis_dout_tuser       = out_user_q;
   assign m_axis_dout_tlast       = out_last_q;
`ifdef SQRT_REM_EN
   assign m_axis_dout_trem        = out_rem_q;
`else
   assign m_axis_dout_trem        = '0;
`endif
   assign inflight                = inflight_q;

endmodule

// File: tb/tb_sqrt_pipe.sv
// Directed bench for sqrt_pipe: DIN_W=16 main instance plus DIN_W=2/10/32 sweep instances.
module tb_sqrt_pipe;

   localparam bit REM_ON =
`ifdef SQRT_REM_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk;
   logic areset;

   logic [15:0] s_tdata;
   logic [7:0]  s_tuser;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic [8:0]  m_trem;
   logic [7:0]  m_tuser;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_ready;
   logic [3:0]  inflight;

   logic [31:0] sw_x32;
   logic [9:0]  sw_x10;
   logic [1:0]  sw_x2;
   logic [3:0]  sw_user;
   logic        sw_last;
   logic        sw_valid;
   logic        sw_ready;

   logic        w2_srdy, w2_last, w2_vld;
   logic [0:0]  w2_data;
   logic [1:0]  w2_rem;
   logic [3:0]  w2_user;
   logic [1:0]  w2_infl;
   logic        w10_srdy, w10_last, w10_vld;
   logic [4:0]  w10_data;
   logic [5:0]  w10_rem;
   logic [3:0]  w10_user;
   logic [2:0]  w10_infl;
   logic        w32_srdy, w32_last, w32_vld;
   logic [15:0] w32_data;
   logic [16:0] w32_rem;
   logic [3:0]  w32_user;
   logic [4:0]  w32_infl;

   int tests;
   int fails;

   sqrt_pipe #(.DIN_W(16), .USER_W(8)) u_dut (
      .aclk(clk), .areset(areset),
      .s_axis_cartesian_tdata(s_tdata), .s_axis_cartesian_tuser(s_tuser),
      .s_axis_cartesian_tlast(s_tlast), .s_axis_cartesian_tvalid(s_tvalid),
      .s_axis_cartesian_tready(s_tready),
      .m_axis_dout_tdata(m_tdata), .m_axis_dout_trem(m_trem), .m_axis_dout_tuser(m_tuser),
      .m_axis_dout_tlast(m_tlast), .m_axis_dout_tvalid(m_tvalid), .m_axis_dout_tready(m_ready),
      .inflight(inflight)
   );

   sqrt_pipe #(.DIN_W(2), .USER_W(4)) u_w2 (
      .aclk(clk), .areset(areset),
      .s_axis_cartesian_tdata(sw_x2), .s_axis_cartesian_tuser(sw_user),
      .s_axis_cartesian_tlast(sw_last), .s_axis_cartesian_tvalid(sw_valid),
      .s_axis_cartesian_tready(w2_srdy),
      .m_axis_dout_tdata(w2_data), .m_axis_dout_trem(w2_rem), .m_axis_dout_tuser(w2_user),
      .m_axis_dout_tlast(w2_last), .m_axis_dout_tvalid(w2_vld), .m_axis_dout_tready(sw_ready),
      .inflight(w2_infl)
   );

   sqrt_pipe #(.DIN_W(10), .USER_W(4)) u_w10 (
      .aclk(clk), .areset(areset),
      .s_axis_cartesian_tdata(sw_x10), .s_axis_cartesian_tuser(sw_user),
      .s_axis_cartesian_tlast(sw_last), .s_axis_cartesian_tvalid(sw_valid),
      .s_axis_cartesian_tready(w10_srdy),
      .m_axis_dout_tdata(w10_data), .m_axis_dout_trem(w10_rem), .m_axis_dout_tuser(w10_user),
      .m_axis_dout_tlast(w10_last), .m_axis_dout_tvalid(w10_vld), .m_axis_dout_tready(sw_ready),
      .inflight(w10_infl)
   );

   sqrt_pipe #(.DIN_W(32), .USER_W(4)) u_w32 (
      .aclk(clk), .areset(areset),
      .s_axis_cartesian_tdata(sw_x32), .s_axis_cartesian_tuser(sw_user),
      .s_axis_cartesian_tlast(sw_last), .s_axis_cartesian_tvalid(sw_valid),
      .s_axis_cartesian_tready(w32_srdy),
      .m_axis_dout_tdata(w32_data), .m_axis_dout_trem(w32_rem), .m_axis_dout_tuser(w32_user),
      .m_axis_dout_tlast(w32_last), .m_axis_dout_tvalid(w32_vld), .m_axis_dout_tready(sw_ready),
      .inflight(w32_infl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned r, c;
      r = 0;
      for (int b = 31; b >= 0; b--) begin
         c = r | (64'd1 << b);
         if (c * c <= x) r = c;
      end
      return r;
   endfunction

   function automatic longint unsigned rem_of(input longint unsigned x);
      longint unsigned r;
      r = isqrt(x);
      return REM_ON ? (x - r * r) : 64'd0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called on a negedge with m_ready=1; output expected after 8 edges including the capture edge.
   task automatic single(input string tag, input logic [15:0] x, input logic [7:0] u,
                         input logic l, input logic [7:0] er, input logic [8:0] erm);
      s_tdata  = x;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0;
      repeat (6) @(negedge clk);
      chk({tag, "_early"}, m_tvalid, 0);
      @(negedge clk);
      chk({tag, "_valid"}, m_tvalid, 1);
      chk({tag, "_root"}, m_tdata, er);
      chk({tag, "_rem"}, m_trem, REM_ON ? erm : 9'd0);
      chk({tag, "_user"}, m_tuser, u);
      chk({tag, "_last"}, m_tlast, l);
      @(negedge clk);
   endtask

   task automatic sweep(input logic [31:0] v);
      int lat2, lat10, lat32;
      logic [0:0]  d2;
      logic [1:0]  r2;
      logic [4:0]  d10;
      logic [5:0]  r10;
      logic [15:0] d32;
      logic [16:0] r32;
      lat2 = 0; lat10 = 0; lat32 = 0;
      d2 = '0; r2 = '0; d10 = '0; r10 = '0; d32 = '0; r32 = '0;
      sw_x2    = v[1:0];
      sw_x10   = v[9:0];
      sw_x32   = v;
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (lat2 == 0 && w2_vld) begin lat2 = c; d2 = w2_data; r2 = w2_rem; end
         if (lat10 == 0 && w10_vld) begin lat10 = c; d10 = w10_data; r10 = w10_rem; end
         if (lat32 == 0 && w32_vld) begin lat32 = c; d32 = w32_data; r32 = w32_rem; end
         @(negedge clk);
      end
      chk("sw2_lat", lat2, 1);
      chk("sw2_root", d2, isqrt(v[1:0]));
      chk("sw2_rem", r2, rem_of(v[1:0]));
      chk("sw10_lat", lat10, 5);
      chk("sw10_root", d10, isqrt(v[9:0]));
      chk("sw10_rem", r10, rem_of(v[9:0]));
      chk("sw32_lat", lat32, 16);
      chk("sw32_root", d32, isqrt(v));
      chk("sw32_rem", r32, rem_of(v));
   endtask

   initial begin
      int in_idx, out_idx, cyc, acc, seen;
      bit stalled;
      logic [7:0] hold_d, hold_u;
      logic [8:0] hold_r;
      longint unsigned bx;

      tests = 0; fails = 0;
      areset = 1'b1;
      s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_ready = 1'b1;
      sw_x2 = '0; sw_x10 = '0; sw_x32 = '0; sw_user = 4'h3; sw_last = 1'b0;
      sw_valid = 1'b0; sw_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_trem", m_trem, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_tready", s_tready, 1);
      areset = 1'b0;
      repeat (10) @(negedge clk);

      // 144 then 169 back-to-back
      s_tvalid = 1'b1; s_tdata = 16'd144; s_tuser = 8'h01; s_tlast = 1'b0;
      @(negedge clk);
      chk("t1_inflight1", inflight, 1);
      s_tdata = 16'd169; s_tuser = 8'h02;
      @(negedge clk);
      chk("t1_inflight2", inflight, 2);
      s_tvalid = 1'b0;
      repeat (5) @(negedge clk);
      chk("t1_not_early", m_tvalid, 0);
      @(negedge clk);
      chk("t1_v0", m_tvalid, 1);
      chk("t1_root0", m_tdata, 12);
      chk("t1_rem0", m_trem, 0);
      chk("t1_user0", m_tuser, 8'h01);
      chk("t1_peak", inflight, 2);
      @(negedge clk);
      chk("t1_v1", m_tvalid, 1);
      chk("t1_root1", m_tdata, 13);
      chk("t1_rem1", m_trem, 0);
      chk("t1_infl_dec", inflight, 1);
      @(negedge clk);
      chk("t1_idle", m_tvalid, 0);
      chk("t1_empty", inflight, 0);

      // Boundary radicands
      single("b0",     16'd0,     8'h00, 1'b0, 8'd0,   9'd0);
      single("b1",     16'd1,     8'h11, 1'b0, 8'd1,   9'd0);
      single("b2",     16'd2,     8'h22, 1'b0, 8'd1,   9'd1);
      single("bmax",   16'd65535, 8'h33, 1'b0, 8'd255, 9'd510);
      single("bside",  16'd65535, 8'hA5, 1'b1, 8'd255, 9'd510);

      // Backpressure with pseudo-random downstream ready
      in_idx = 0; out_idx = 0; cyc = 0; stalled = 1'b0;
      hold_d = '0; hold_u = '0; hold_r = '0;
      while (out_idx < 20 && cyc < 400) begin
         if (stalled) begin
            chk("bp_hold_valid", m_tvalid, 1);
            chk("bp_hold_data", m_tdata, hold_d);
            chk("bp_hold_user", m_tuser, hold_u);
            chk("bp_hold_rem", m_trem, hold_r);
         end
         m_ready  = 1'($urandom_range(0, 1));
         s_tvalid = (in_idx < 20);
         s_tdata  = 16'(in_idx * 3000 + 7);
         s_tuser  = 8'(in_idx);
         s_tlast  = (in_idx == 19);
         #1;
         stalled = 1'b0;
         if (m_tvalid) begin
            if (m_ready) begin
               bx = longint'(out_idx * 3000 + 7);
               chk("bp_root", m_tdata, isqrt(bx));
               chk("bp_rem", m_trem, rem_of(bx));
               chk("bp_order", m_tuser, out_idx);
               chk("bp_last", m_tlast, out_idx == 19);
               out_idx++;
            end else begin
               chk("bp_tready_low", s_tready, 0);
               stalled = 1'b1;
               hold_d = m_tdata; hold_u = m_tuser; hold_r = m_trem;
            end
         end
         if (s_tvalid && s_tready) in_idx++;
         @(negedge clk);
         cyc++;
      end
      chk("bp_all_out", out_idx, 20);
      chk("bp_all_in", in_idx, 20);
      s_tvalid = 1'b0; s_tlast = 1'b0; m_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("bp_no_dup", m_tvalid, 0);
      chk("bp_drained", inflight, 0);

      // Full-pipe stall
      m_ready = 1'b0; acc = 0;
      for (int c = 0; c < 12; c++) begin
         s_tvalid = 1'b1;
         s_tdata  = 16'(400 + acc);
         s_tuser  = 8'(acc);
         #1;
         if (s_tready) acc++;
         @(negedge clk);
      end
      chk("fs_accepted", acc, 8);
      chk("fs_tready", s_tready, 0);
      chk("fs_inflight", inflight, 8);
      s_tvalid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("fs_valid", m_tvalid, 1);
         chk("fs_root", m_tdata, 20);
         chk("fs_rem", m_trem, rem_of(400 + i));
         chk("fs_user", m_tuser, i);
         @(negedge clk);
      end
      #1;
      chk("fs_empty_v", m_tvalid, 0);
      chk("fs_empty_n", inflight, 0);
      @(negedge clk);

      // Reset with 5 beats in flight
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 16'(100 + i * 50);
         s_tuser  = 8'hF0 + 8'(i);
         s_tlast  = 1'b1;
         @(negedge clk);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      chk("mr_pre_inflight", inflight, 5);
      areset = 1'b1;
      #1;
      chk("mr_tvalid", m_tvalid, 0);
      chk("mr_tdata", m_tdata, 0);
      chk("mr_trem", m_trem, 0);
      chk("mr_tuser", m_tuser, 0);
      chk("mr_tlast", m_tlast, 0);
      chk("mr_inflight", inflight, 0);
      @(negedge clk);
      areset = 1'b0;
      #1;
      chk("mr_tready", s_tready, 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_tvalid) seen++;
      end
      chk("mr_no_stale", seen, 0);
      single("mr_new", 16'd4, 8'h44, 1'b0, 8'd2, 9'd0);

      // Width sweep
      sweep(32'd0);
      sweep(32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         sweep($urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
